// File: rtl/usb_pkg.sv
// Shared USB transmit types and defaults.
// Used by the TX sequencer and its bit-stuff counter.
package usb_pkg;

  localparam logic [7:0] SYNC_PAT_DEF  = 8'h80;
  localparam int         STUFF_LEN_DEF = 6;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

endpackage

// File: rtl/bit_stuff_ctr.sv
// Consecutive-ones counter and stuff-bit decision.
// stuff_req flags the bit that completes a run of STUFF_LEN ones.
module bit_stuff_ctr
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic emit,
  input  logic bit_in,
  output logic stuff_req
);

  localparam int CW = $clog2(STUFF_LEN + 1);

  logic [CW-1:0] ones;

  assign stuff_req = emit && bit_in &&
                     (ones == CW'(STUFF_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      ones <= '0;
    end else if (!emit || !bit_in || stuff_req) begin
      ones <= '0;
    end else begin
      ones <= ones + CW'(1);
    end
  end

endmodule

// File: rtl/usb_tx_seq.sv
// USB packet transmit sequencer: SYNC, data, bit stuffing, EOP.
// All outputs are registered from the next-state context.
module usb_tx_seq
  import usb_pkg::*;
#(
  parameter logic [7:0] SYNC_PAT  = SYNC_PAT_DEF,
  parameter int         STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       se0,
  output logic       tx_active,
  output logic       underrun
);

  tx_state_t  state;
  tx_state_t  ret;
  logic [7:0] sh;
  logic [2:0] bcnt;
  logic       last;

  tx_state_t  ns;
  tx_state_t  nret;
  logic [7:0] nsh;
  logic [2:0] ncnt;
  logic       nlast;
  logic       nur;

  logic       stuff_req;

  bit_stuff_ctr #(
    .STUFF_LEN(STUFF_LEN)
  ) u_stuff (
    .clk      (clk),
    .rst      (rst),
    .emit     (bit_valid),
    .bit_in   (bit_out),
    .stuff_req(stuff_req)
  );

  // The context after a bit is settled before any stuff bit,
  // so STUFF only has to resume at ret with sh/bcnt as stored.
  always_comb begin
    ns    = state;
    nret  = ret;
    nsh   = sh;
    ncnt  = bcnt;
    nlast = last;
    nur   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          ns    = SYNC;
          nsh   = SYNC_PAT;
          ncnt  = 3'd0;
          nlast = 1'b0;
        end
      end
      SYNC, DATA: begin
        if (bcnt != 3'd7) begin
          nsh  = sh >> 1;
          ncnt = bcnt + 3'd1;
        end else if (state == DATA && last) begin
          ns   = EOP_SE0;
          ncnt = 3'd0;
        end else if (byte_valid) begin
          ns    = DATA;
          nsh   = byte_data;
          ncnt  = 3'd0;
          nlast = byte_last;
        end else begin
          ns   = EOP_SE0;
          ncnt = 3'd0;
          nur  = 1'b1;
        end
        if (stuff_req && !nur) begin
          nret = ns;
          ns   = STUFF;
        end
      end
      STUFF: begin
        ns = ret;
      end
      EOP_SE0: begin
        if (bcnt == 3'd0) begin
          ncnt = 3'd1;
        end else begin
          ns = EOP_J;
        end
      end
      EOP_J: begin
        ns = IDLE;
      end
      default: begin
        ns = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ret        <= IDLE;
      sh         <= '0;
      bcnt       <= '0;
      last       <= 1'b0;
      byte_ready <= 1'b0;
      bit_out    <= 1'b1;
      bit_valid  <= 1'b0;
      se0        <= 1'b0;
      tx_active  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state     <= ns;
      ret       <= nret;
      sh        <= nsh;
      bcnt      <= ncnt;
      last      <= nlast;
      underrun  <= nur;
      se0       <= (ns == EOP_SE0);
      tx_active <= (ns != IDLE);
      bit_valid <= (ns == SYNC) || (ns == DATA) ||
                   (ns == STUFF);
      if (ns == STUFF) begin
        bit_out <= 1'b0;
      end else if (ns == SYNC || ns == DATA) begin
        bit_out <= nsh[0];
      end else begin
        bit_out <= 1'b1;
      end
      byte_ready <= (ncnt == 3'd7) &&
                    ((ns == SYNC) || (ns == DATA && !nlast));
    end
  end

endmodule

// File: tb/tb_usb_tx_seq.sv
// Self-checking bench for usb_tx_seq against a bit-list
// reference model built from the packet bytes.
module tb_usb_tx_seq;
  import usb_pkg::*;

  localparam int SL = STUFF_LEN_DEF;
  localparam logic [5:0] IDLE_V = 6'b100000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       se0;
  logic       tx_active;
  logic       underrun;

  always #5 clk = ~clk;

  usb_tx_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_last (byte_last),
    .byte_ready(byte_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .se0       (se0),
    .tx_active (tx_active),
    .underrun  (underrun)
  );

  int errors = 0;
  int checks = 0;
  int pno = 0;
  int idx;
  int fail_idx;
  int ones;
  int act;
  logic [7:0] pkt[$];
  logic [5:0] exp_q[$];

  // {bit_out, bit_valid, se0, tx_active, byte_ready, underrun}
  function automatic logic [5:0] obs();
    return {bit_out, bit_valid, se0, tx_active, byte_ready, underrun};
  endfunction

  task automatic chk(input string tag, input logic [5:0] o,
                     input logic [5:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, o, e);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, o, e);
    end
  endtask

  task automatic push_bit(input logic b, input logic rdy,
                          input logic nostuff);
    exp_q.push_back({b, 1'b1, 1'b0, 1'b1, rdy, 1'b0});
    ones = b ? ones + 1 : 0;
    if (ones == SL && !nostuff) begin
      exp_q.push_back(6'b010100);
      ones = 0;
    end
  endtask

  task automatic build_model();
    logic [7:0] sp;
    logic ur;
    logic rdy;
    logic brk;
    sp = SYNC_PAT_DEF;
    ur = 1'b0;
    ones = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      brk = (i == 7) && (fail_idx == 0);
      push_bit(sp[i], i == 7, brk);
    end
    if (fail_idx == 0) ur = 1'b1;
    for (int k = 0; k < pkt.size() && !ur; k++) begin
      for (int i = 0; i < 8 && !ur; i++) begin
        rdy = (i == 7) && (k != pkt.size() - 1);
        brk = rdy && (fail_idx == k + 1);
        push_bit(pkt[k][i], rdy, brk);
        if (brk) ur = 1'b1;
      end
    end
    exp_q.push_back({5'b10110, ur});
    exp_q.push_back(6'b101100);
    exp_q.push_back(6'b100100);
    exp_q.push_back(IDLE_V);
  endtask

  task automatic drive_inputs();
    if (idx < pkt.size()) begin
      byte_data  = pkt[idx];
      byte_valid = (idx != fail_idx);
      byte_last  = (idx == pkt.size() - 1);
    end else begin
      byte_data  = 8'($urandom);
      byte_valid = 1'b0;
      byte_last  = 1'($urandom);
    end
  endtask

  task automatic run_packet(input int start_mid, output int na);
    logic take;
    pno++;
    build_model();
    idx = 0;
    na = 0;
    drive_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      chk($sformatf("pkt%0d cyc%0d", pno, c), obs(), exp_q[c]);
      if (tx_active) na++;
      take = byte_ready && byte_valid;
      start = (c == start_mid);
      @(posedge clk); #1;
      if (take) idx++;
      drive_inputs();
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    byte_data = 8'h00;
    byte_valid = 1'b0;
    byte_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", obs(), IDLE_V);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle", obs(), IDLE_V);

    pkt = '{8'hA5}; fail_idx = -1;
    run_packet(-1, act);
    chk_int("A5 len", act, 19);

    pkt = '{8'hFF}; fail_idx = -1;
    run_packet(-1, act);
    chk_int("FF len", act, 20);

    pkt = '{8'hFF, 8'hFF}; fail_idx = -1;
    run_packet(-1, act);
    chk_int("FFFF len", act, 29);

    pkt = '{8'h3C, 8'h55}; fail_idx = 1;
    run_packet(-1, act);
    chk_int("ur consumed", idx, 1);

    pkt = '{8'h5A, 8'h01}; fail_idx = -1;
    run_packet(12, act);
    chk_int("midstart len", act, 27);

    // reset while DATA bit 3 of the first byte is on the line
    pno++;
    pkt = '{8'h00, 8'h12}; fail_idx = -1;
    build_model();
    idx = 0;
    drive_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("rstpkt cyc%0d", c), obs(), exp_q[c]);
      if (c != 11) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst", obs(), IDLE_V);
    @(posedge clk); #1;
    chk("midrst idle", obs(), IDLE_V);
    pkt = '{8'hC3}; fail_idx = -1;
    run_packet(-1, act);
    chk_int("after rst len", act, 19);

    for (int p = 0; p < 25; p++) begin
      int n;
      int g;
      n = $urandom_range(1, 4);
      pkt.delete();
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) == 0) pkt.push_back(8'hFF);
        else pkt.push_back(8'($urandom));
      end
      fail_idx = ($urandom_range(0, 4) == 0) ?
                 int'($urandom_range(0, n - 1)) : -1;
      run_packet(-1, act);
      chk_int($sformatf("rnd%0d len", p), act, exp_q.size() - 1);
      g = $urandom_range(0, 3);
      for (int i = 0; i < g; i++) begin
        byte_data = 8'($urandom);
        byte_valid = 1'($urandom);
        @(posedge clk); #1;
        chk($sformatf("gap%0d", p), obs(), IDLE_V);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
